// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor with a direct-mapped BTB for fetch.
// Ports: clk, reset, current_pc -> predicted_pc/pred_taken/pred_ghr; update_* from EX.
module gshare_branch_predictor #(
   parameter int INDEX_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           current_pc,
   output logic [31:0]           predicted_pc,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_ghr,
   input  logic                  update_valid,
   input  logic [31:0]           update_pc,
   input  logic [31:0]           update_target,
   input  logic                  update_taken,
   input  logic                  update_is_cond,
   input  logic [INDEX_BITS-1:0] update_ghr
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   logic                  r_valid  [ENTRIES];
   logic                  r_uncond [ENTRIES];
   logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
   logic [31:0]           r_target [ENTRIES];
   logic [1:0]            r_pht    [ENTRIES];
   logic [INDEX_BITS-1:0] r_ghr;

   logic [INDEX_BITS-1:0] w_bidx;
   logic [INDEX_BITS-1:0] w_pidx;
   logic [TAG_BITS-1:0]   w_tag;
   logic                  w_hit;
   logic [INDEX_BITS-1:0] w_ubidx;
   logic [INDEX_BITS-1:0] w_upidx;
   logic [TAG_BITS-1:0]   w_utag;
   logic [1:0]            w_pht_cur;
   logic [1:0]            w_pht_next;
   logic                  w_unused;

   // Byte-offset bits never participate in indexing.
   assign w_unused = ^{current_pc[1:0], update_pc[1:0]};

   // Prediction path
   assign w_bidx = current_pc[INDEX_BITS+1:2];
   assign w_tag  = current_pc[31:INDEX_BITS+2];
   assign w_pidx = w_bidx ^ r_ghr;
   assign w_hit  = r_valid[w_bidx] && (r_tag[w_bidx] == w_tag);

   assign pred_taken   = w_hit && (r_uncond[w_bidx] || r_pht[w_pidx][1]);
   assign predicted_pc = pred_taken ? r_target[w_bidx]
                                    : current_pc + 32'd4;
   assign pred_ghr     = r_ghr;

   // Training path: use the history snapshot taken at fetch so the
   // same counter that predicted is the one trained.
   assign w_ubidx = update_pc[INDEX_BITS+1:2];
   assign w_utag  = update_pc[31:INDEX_BITS+2];
   assign w_upidx = w_ubidx ^ update_ghr;

   always_comb begin
      w_pht_cur  = r_pht[w_upidx];
      w_pht_next = w_pht_cur;
      if (update_taken) begin
         if (w_pht_cur != 2'b11) begin
            w_pht_next = w_pht_cur + 2'b01;
         end
      end else begin
         if (w_pht_cur != 2'b00) begin
            w_pht_next = w_pht_cur - 2'b01;
         end
      end
   end

   // Valid bits, counters and history carry reset state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_pht[i]   <= 2'b01;
         end
         r_ghr <= '0;
      end else if (update_valid) begin
         if (update_is_cond) begin
            r_pht[w_upidx] <= w_pht_next;
            r_ghr <= {r_ghr[INDEX_BITS-2:0], update_taken};
         end
         if (update_taken) begin
            r_valid[w_ubidx] <= 1'b1;
         end
      end
   end

   // Entry payload is qualified by the valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!reset && update_valid && update_taken) begin
         r_tag[w_ubidx]    <= w_utag;
         r_target[w_ubidx] <= update_target;
         r_uncond[w_ubidx] <= !update_is_cond;
      end
   end

endmodule
